// File: rtl/tdc_pkg.sv
// Shared types and default widths for the TDC measurement sequencer.
`timescale 1ns/1ps
package tdc_pkg;

   localparam int COARSE_W_DEF    = 16;
   localparam int FINE_W_DEF      = 8;
   localparam int TIMEOUT_CYC_DEF = 4000;
   localparam int FINE_WAIT_DEF   = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_START,
      ST_MEASURE,
      ST_WAIT_FINE,
      ST_OUTPUT
   } tdc_state_t;

   typedef struct packed {
      logic [COARSE_W_DEF-1:0] coarse;
      logic [FINE_W_DEF-1:0]   fine_start;
      logic [FINE_W_DEF-1:0]   fine_stop;
      logic                    timeout;
      logic                    fine_err;
      logic                    last;
   } tdc_res_t;

endpackage

// File: rtl/tdc_fine_capture.sv
// Two-channel first-valid latch for the start/stop fine delay-line codes.
`timescale 1ns/1ps
module tdc_fine_capture
   import tdc_pkg::*;
#(
   parameter int FINE_W = FINE_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_en,
   input  logic              i_start_valid,
   input  logic [FINE_W-1:0] i_start_code,
   input  logic              i_stop_valid,
   input  logic [FINE_W-1:0] i_stop_code,
   output logic              o_start_cap,
   output logic [FINE_W-1:0] o_start_code,
   output logic              o_stop_cap,
   output logic [FINE_W-1:0] o_stop_code
);

   logic              r_start_cap;
   logic [FINE_W-1:0] r_start_code;
   logic              r_stop_cap;
   logic [FINE_W-1:0] r_stop_code;

   // Once a channel's flag is set, later valids leave its code untouched.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_start_cap  <= 1'b0;
         r_start_code <= '0;
         r_stop_cap   <= 1'b0;
         r_stop_code  <= '0;
      end else if (i_clr) begin
         r_start_cap <= 1'b0;
         r_stop_cap  <= 1'b0;
      end else if (i_en) begin
         if (i_start_valid && !r_start_cap) begin
            r_start_cap  <= 1'b1;
            r_start_code <= i_start_code;
         end
         if (i_stop_valid && !r_stop_cap) begin
            r_stop_cap  <= 1'b1;
            r_stop_code <= i_stop_code;
         end
      end
   end

   assign o_start_cap  = r_start_cap;
   assign o_start_code = r_start_code;
   assign o_stop_cap   = r_stop_cap;
   assign o_stop_code  = r_stop_code;

endmodule

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: burst arming, coarse counting, fine-code
// collection, timeout/abort handling and a registered valid/ready result.
`timescale 1ns/1ps
module tdc_meas_ctrl
   import tdc_pkg::*;
#(
   parameter int COARSE_W    = COARSE_W_DEF,
   parameter int FINE_W      = FINE_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int FINE_WAIT   = FINE_WAIT_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                arm_valid,
   output logic                arm_ready,
   input  logic [7:0]          arm_count,
   input  logic                abort,
   input  logic                tdc_start,
   input  logic                tdc_stop,
   input  logic                fine_start_valid,
   input  logic [FINE_W-1:0]   fine_start_code,
   input  logic                fine_stop_valid,
   input  logic [FINE_W-1:0]   fine_stop_code,
   output logic                fe_enable,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [COARSE_W-1:0] res_coarse,
   output logic [FINE_W-1:0]   res_fine_start,
   output logic [FINE_W-1:0]   res_fine_stop,
   output logic                res_timeout,
   output logic                res_fine_err,
   output logic                res_last,
   output logic                busy
);

   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam int FW_W  = $clog2(FINE_WAIT + 1);

   tdc_state_t          r_state;
   tdc_state_t          w_next;
   logic [COARSE_W-1:0] r_coarse;
   logic [TMO_W-1:0]    r_tmo;
   logic [FW_W-1:0]     r_fwait;
   logic [7:0]          r_remaining;
   logic [COARSE_W-1:0] r_res_coarse;
   logic [FINE_W-1:0]   r_res_fs;
   logic [FINE_W-1:0]   r_res_ft;
   logic                r_res_tmo;
   logic                r_res_err;
   logic                r_res_last;

   logic                w_cap_start;
   logic                w_cap_stop;
   logic [FINE_W-1:0]   w_code_start;
   logic [FINE_W-1:0]   w_code_stop;
   logic                w_tmo_hit;
   logic                w_fine_done;
   logic                w_enter_ws;
   logic                w_enter_out;

   assign w_tmo_hit   = (r_tmo == TMO_W'(TIMEOUT_CYC));
   assign w_fine_done = (w_cap_start && w_cap_stop) ||
                        (r_fwait == FW_W'(FINE_WAIT - 1));
   assign w_enter_ws  = (w_next == ST_WAIT_START) && (r_state != ST_WAIT_START);
   assign w_enter_out = (w_next == ST_OUTPUT) && (r_state != ST_OUTPUT);

   tdc_fine_capture #(.FINE_W(FINE_W)) u_fine (
      .i_clk         (clk),
      .i_rst_n       (reset_n),
      .i_clr         ((r_state == ST_WAIT_START) && tdc_start),
      .i_en          ((r_state == ST_MEASURE) || (r_state == ST_WAIT_FINE)),
      .i_start_valid (fine_start_valid),
      .i_start_code  (fine_start_code),
      .i_stop_valid  (fine_stop_valid),
      .i_stop_code   (fine_stop_code),
      .o_start_cap   (w_cap_start),
      .o_start_code  (w_code_start),
      .o_stop_cap    (w_cap_stop),
      .o_stop_code   (w_code_stop)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   // Timeout beats start/stop in the same cycle; abort beats everything.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:       if (arm_valid) w_next = ST_WAIT_START;
         ST_WAIT_START: if (w_tmo_hit) w_next = ST_OUTPUT;
                        else if (tdc_start) w_next = ST_MEASURE;
         ST_MEASURE:    if (w_tmo_hit) w_next = ST_OUTPUT;
                        else if (tdc_stop) w_next = ST_WAIT_FINE;
         ST_WAIT_FINE:  if (w_fine_done) w_next = ST_OUTPUT;
         ST_OUTPUT:     if (res_ready) w_next = (r_remaining > 8'd1) ? ST_WAIT_START : ST_IDLE;
         default:       w_next = ST_IDLE;
      endcase
      if (abort) w_next = ST_IDLE;
   end

   // Coarse is held at 0 throughout WAIT_START so a timeout without a start reports 0.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_coarse    <= '0;
         r_tmo       <= '0;
         r_fwait     <= '0;
         r_remaining <= '0;
      end else begin
         if (r_state == ST_WAIT_START)
            r_coarse <= '0;
         else if ((r_state == ST_MEASURE) && (r_coarse != '1))
            r_coarse <= r_coarse + 1'b1;

         if (w_enter_ws)
            r_tmo <= '0;
         else if (((r_state == ST_WAIT_START) || (r_state == ST_MEASURE)) && !w_tmo_hit)
            r_tmo <= r_tmo + 1'b1;

         if (r_state != ST_WAIT_FINE) r_fwait <= '0;
         else                         r_fwait <= r_fwait + 1'b1;

         if ((r_state == ST_IDLE) && w_enter_ws)
            r_remaining <= (arm_count == 8'd0) ? 8'd1 : arm_count;
         else if ((r_state == ST_OUTPUT) && w_enter_ws)
            r_remaining <= r_remaining - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_res_coarse <= '0;
         r_res_fs     <= '0;
         r_res_ft     <= '0;
         r_res_tmo    <= 1'b0;
         r_res_err    <= 1'b0;
         r_res_last   <= 1'b0;
      end else begin
         if ((r_state == ST_MEASURE) && (w_next == ST_WAIT_FINE))
            r_res_coarse <= r_coarse;
         if (w_enter_out) begin
            r_res_last <= (r_remaining == 8'd1);
            if (r_state == ST_WAIT_FINE) begin
               r_res_fs  <= w_cap_start ? w_code_start : '0;
               r_res_ft  <= w_cap_stop  ? w_code_stop  : '0;
               r_res_tmo <= 1'b0;
               r_res_err <= !(w_cap_start && w_cap_stop);
            end else begin
               r_res_coarse <= r_coarse;
               r_res_fs     <= '0;
               r_res_ft     <= '0;
               r_res_tmo    <= 1'b1;
               r_res_err    <= 1'b0;
            end
         end
      end
   end

   assign arm_ready      = (r_state == ST_IDLE);
   assign fe_enable      = (r_state == ST_WAIT_START) || (r_state == ST_MEASURE) ||
                           (r_state == ST_WAIT_FINE);
   assign busy           = (r_state != ST_IDLE);
   assign res_valid      = (r_state == ST_OUTPUT);
   assign res_coarse     = r_res_coarse;
   assign res_fine_start = r_res_fs;
   assign res_fine_stop  = r_res_ft;
   assign res_timeout    = r_res_tmo;
   assign res_fine_err   = r_res_err;
   assign res_last       = r_res_last;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Scoreboard bench for tdc_meas_ctrl: a 16-bit instance with a short timeout
// and a 4-bit-coarse instance for the saturation case.
`timescale 1ns/1ps
module tb_tdc_meas_ctrl;
   import tdc_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A
   logic        a_arm_valid = 0, a_arm_ready, a_abort = 0, a_start = 0, a_stop = 0;
   logic [7:0]  a_arm_count = 0;
   logic        a_fsv = 0, a_ftv = 0;
   logic [7:0]  a_fsc = 0, a_ftc = 0;
   logic        a_fe, a_res_valid, a_res_ready = 1, a_tmo, a_err, a_last, a_busy;
   logic [15:0] a_coarse;
   logic [7:0]  a_rfs, a_rft;

   // Instance B
   logic        b_arm_valid = 0, b_arm_ready, b_abort = 0, b_start = 0, b_stop = 0;
   logic [7:0]  b_arm_count = 0;
   logic        b_fsv = 0, b_ftv = 0;
   logic [7:0]  b_fsc = 0, b_ftc = 0;
   logic        b_fe, b_res_valid, b_res_ready = 1, b_tmo, b_err, b_last, b_busy;
   logic [3:0]  b_coarse;
   logic [7:0]  b_rfs, b_rft;

   tdc_meas_ctrl #(.COARSE_W(16), .FINE_W(8), .TIMEOUT_CYC(50), .FINE_WAIT(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .arm_valid(a_arm_valid), .arm_ready(a_arm_ready),
      .arm_count(a_arm_count), .abort(a_abort), .tdc_start(a_start), .tdc_stop(a_stop),
      .fine_start_valid(a_fsv), .fine_start_code(a_fsc),
      .fine_stop_valid(a_ftv), .fine_stop_code(a_ftc),
      .fe_enable(a_fe), .res_valid(a_res_valid), .res_ready(a_res_ready),
      .res_coarse(a_coarse), .res_fine_start(a_rfs), .res_fine_stop(a_rft),
      .res_timeout(a_tmo), .res_fine_err(a_err), .res_last(a_last), .busy(a_busy));

   tdc_meas_ctrl #(.COARSE_W(4), .FINE_W(8), .TIMEOUT_CYC(50), .FINE_WAIT(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .arm_valid(b_arm_valid), .arm_ready(b_arm_ready),
      .arm_count(b_arm_count), .abort(b_abort), .tdc_start(b_start), .tdc_stop(b_stop),
      .fine_start_valid(b_fsv), .fine_start_code(b_fsc),
      .fine_stop_valid(b_ftv), .fine_stop_code(b_ftc),
      .fe_enable(b_fe), .res_valid(b_res_valid), .res_ready(b_res_ready),
      .res_coarse(b_coarse), .res_fine_start(b_rfs), .res_fine_stop(b_rft),
      .res_timeout(b_tmo), .res_fine_err(b_err), .res_last(b_last), .busy(b_busy));

   tdc_res_t exp_a[$];
   tdc_res_t exp_b[$];

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   function automatic tdc_res_t mk(input int c, input int fs, input int ft,
                                   input bit t, input bit e, input bit l);
      tdc_res_t r;
      r.coarse     = 16'(c);
      r.fine_start = 8'(fs);
      r.fine_stop  = 8'(ft);
      r.timeout    = t;
      r.fine_err   = e;
      r.last       = l;
      return r;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input bit sel_b, output int n);
      n = 0;
      while (!(sel_b ? b_res_valid : a_res_valid) && n < 200) begin
         tick(1);
         n++;
      end
   endtask

   // Monitors: compare every cycle a record is presented, pop on handshake.
   always @(negedge clk) begin
      tdc_res_t act;
      if (a_res_valid) begin
         act = mk(int'(a_coarse), int'(a_rfs), int'(a_rft), a_tmo, a_err, a_last);
         if (exp_a.size() == 0) cmp("recA_unexpected", 64'(act), 64'(1'b0) - 64'd1);
         else begin
            cmp("recA", 64'(act), 64'(exp_a[0]));
            if (a_res_ready) void'(exp_a.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      tdc_res_t act;
      if (b_res_valid) begin
         act = mk(int'(b_coarse), int'(b_rfs), int'(b_rft), b_tmo, b_err, b_last);
         if (exp_b.size() == 0) cmp("recB_unexpected", 64'(act), 64'(1'b0) - 64'd1);
         else begin
            cmp("recB", 64'(act), 64'(exp_b[0]));
            if (b_res_ready) void'(exp_b.pop_front());
         end
      end
   end

   initial begin
      int n;
      tick(3);
      reset_n = 1'b1;
      tick(1);
      cmp("rst_arm_ready", a_arm_ready, 1);
      cmp("rst_fe_enable", a_fe, 0);
      cmp("rst_res_valid", a_res_valid, 0);
      cmp("rst_busy", a_busy, 0);
      cmp("rst_flags", {a_tmo, a_err, a_last}, 0);
      cmp("rst_data", {a_coarse, a_rfs, a_rft}, 0);

      // Single measurement: start at +10, stop at +20 after that
      exp_a.push_back(mk(19, 'h12, 'h34, 0, 0, 1));
      a_arm_count = 1; a_arm_valid = 1; tick(1); a_arm_valid = 0;
      cmp("arm_fe_enable", a_fe, 1);
      cmp("arm_ready_low", a_arm_ready, 0);
      tick(9);
      a_start = 1; tick(1); a_start = 0;
      a_fsv = 1; a_fsc = 8'h12; tick(1); a_fsv = 0;
      tick(18);
      a_stop = 1; tick(1); a_stop = 0;
      a_ftv = 1; a_ftc = 8'h34; tick(1); a_ftv = 0;
      cmp("single_valid_early", a_res_valid, 0);
      tick(1);
      cmp("single_valid", a_res_valid, 1);
      cmp("single_busy", a_busy, 1);
      tick(1);
      cmp("single_busy_after", a_busy, 0);
      cmp("single_arm_ready", a_arm_ready, 1);

      // Timeout with arm_count 0 (treated as 1)
      exp_a.push_back(mk(0, 0, 0, 1, 0, 1));
      a_arm_count = 0; a_arm_valid = 1; tick(1); a_arm_valid = 0;
      wait_valid(0, n);
      cmp("tmo_latency", n, 51);
      cmp("tmo_fe_enable", a_fe, 0);
      tick(1);
      cmp("tmo_busy_after", a_busy, 0);

      // Missing stop fine code
      exp_a.push_back(mk(4, 'h55, 0, 0, 1, 1));
      a_arm_count = 1; a_arm_valid = 1; tick(1); a_arm_valid = 0;
      tick(2);
      a_start = 1; tick(1); a_start = 0;
      a_fsv = 1; a_fsc = 8'h55; tick(1); a_fsv = 0;
      tick(3);
      a_stop = 1; tick(1); a_stop = 0;
      wait_valid(0, n);
      cmp("fine_wait_latency", n, 4);
      tick(1);
      cmp("fine_err_busy_after", a_busy, 0);

      // Burst of 3 with 5-cycle backpressure per record
      a_res_ready = 0;
      a_arm_count = 3; a_arm_valid = 1; tick(1); a_arm_valid = 0;
      for (int i = 0; i < 3; i++) begin
         exp_a.push_back(mk(2 + 2 * i, 'h10 + i, 'h20 + i, 0, 0, i == 2));
         tick(1);
         a_start = 1; tick(1); a_start = 0;
         a_fsv = 1; a_fsc = 8'(8'h10 + i); tick(1); a_fsv = 0;
         tick(1 + 2 * i);
         a_stop = 1; tick(1); a_stop = 0;
         a_ftv = 1; a_ftc = 8'(8'h20 + i); tick(1); a_ftv = 0;
         wait_valid(0, n);
         cmp("burst_latency", n, 1);
         cmp("burst_fe_low", a_fe, 0);
         if (i == 0) a_start = 1;
         tick(1);
         a_start = 0;
         tick(4);
         cmp("burst_still_valid", a_res_valid, 1);
         a_res_ready = 1; tick(1); a_res_ready = 0;
         if (i < 2) cmp("burst_fe_back", a_fe, 1);
         else       cmp("burst_busy_after", a_busy, 0);
      end
      a_res_ready = 1;

      // Abort mid-MEASURE, then immediate re-arm
      a_arm_count = 2; a_arm_valid = 1; tick(1); a_arm_valid = 0;
      tick(1);
      a_start = 1; tick(1); a_start = 0;
      tick(3);
      a_abort = 1; tick(1); a_abort = 0;
      cmp("abort_busy", a_busy, 0);
      cmp("abort_fe", a_fe, 0);
      cmp("abort_arm_ready", a_arm_ready, 1);
      cmp("abort_res_valid", a_res_valid, 0);
      exp_a.push_back(mk(1, 'h66, 'h77, 0, 0, 1));
      a_arm_count = 1; a_arm_valid = 1; tick(1); a_arm_valid = 0;
      cmp("rearm_fe", a_fe, 1);
      a_start = 1; tick(1); a_start = 0;
      a_fsv = 1; a_fsc = 8'h66; tick(1); a_fsv = 0;
      a_stop = 1; tick(1); a_stop = 0;
      a_ftv = 1; a_ftc = 8'h77; tick(1); a_ftv = 0;
      wait_valid(0, n);
      cmp("rearm_latency", n, 1);
      tick(1);
      cmp("rearm_busy_after", a_busy, 0);

      // Coincident start/stop and coarse saturation on the 4-bit instance
      exp_b.push_back(mk(15, 'hA1, 'hB2, 0, 0, 1));
      b_arm_count = 1; b_arm_valid = 1; tick(1); b_arm_valid = 0;
      tick(1);
      b_start = 1; b_stop = 1; tick(1); b_start = 0; b_stop = 0;
      b_fsv = 1; b_fsc = 8'hA1; tick(1); b_fsv = 0;
      tick(18);
      cmp("coinc_fe", b_fe, 1);
      cmp("coinc_no_valid", b_res_valid, 0);
      b_stop = 1; tick(1); b_stop = 0;
      b_ftv = 1; b_ftc = 8'hB2; tick(1); b_ftv = 0;
      wait_valid(1, n);
      cmp("sat_latency", n, 1);
      tick(1);
      cmp("sat_busy_after", b_busy, 0);

      tick(3);
      cmp("expA_drained", exp_a.size(), 0);
      cmp("expB_drained", exp_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer for the TDC front end. It arms the start/stop edge qualifier and accepts burst commands from the host. It counts coarse `clk` periods between the qualified `TDC_start` and `TDC_stop` pulses, collects the two fine delay-line codes and returns one result record per measurement over a valid/ready interface. It sits between the host register block and the edge-qualifier/delay-line datapath, and adds timeout and abort handling.

## Interface
- `COARSE_W`, default 16: coarse counter and result width.
- `FINE_W`, default 8: fine code width.
- `TIMEOUT_CYC`, default 4000: maximum cycles spent in WAIT_START plus MEASURE before a forced timeout.
- `FINE_WAIT`, default 4: maximum cycles spent in WAIT_FINE.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `arm_valid`  in  1  burst command valid.
- `arm_ready`  out  1  command accepted when high with `arm_valid`.
- `arm_count`  in  8  number of measurements in the burst; 0 is treated as 1.
- `abort`  in  1  synchronous abort, one cycle.
- `tdc_start`  in  1  qualified start pulse from the edge qualifier.
- `tdc_stop`  in  1  qualified stop pulse from the edge qualifier.
- `fine_start_valid`  in  1  start fine code valid.
- `fine_start_code`  in  FINE_W  start fine code.
- `fine_stop_valid`  in  1  stop fine code valid.
- `fine_stop_code`  in  FINE_W  stop fine code.
- `fe_enable`  out  1  enables the front end; high in WAIT_START, MEASURE and WAIT_FINE.
- `res_valid`  out  1  result record valid.
- `res_ready`  in  1  host accepts the result.
- `res_coarse`  out  COARSE_W  coarse count.
- `res_fine_start`  out  FINE_W  start fine code.
- `res_fine_stop`  out  FINE_W  stop fine code.
- `res_timeout`  out  1  measurement timed out.
- `res_fine_err`  out  1  a fine code was missing.
- `res_last`  out  1  final record of the burst.
- `busy`  out  1  state is not IDLE.

## Operation
- State encoding: IDLE, WAIT_START, MEASURE, WAIT_FINE, OUTPUT.
- **IDLE**
  - `arm_ready`=1.
  - On `arm_valid`: load `remaining` = max(`arm_count`,1), go to WAIT_START.
- **WAIT_START**
  - Timeout counter runs.
  - On `tdc_start`: clear `coarse` to 0, clear the fine-captured flags, go to MEASURE.
  - `tdc_stop` is ignored in this state, including when it coincides with `tdc_start`.
- **MEASURE**
  - `coarse` increments each cycle and saturates at all-ones.
  - Further `tdc_start` pulses are ignored.
  - On `tdc_stop`: latch `res_coarse` = `coarse` (the pre-increment value of that cycle), go to WAIT_FINE.
- **Fine-code capture**
  - Active in MEASURE and WAIT_FINE.
  - The first `fine_*_valid` of each channel latches its code; later valids are ignored.
- **WAIT_FINE**
  - Exit to OUTPUT when both codes are captured, or after `FINE_WAIT` cycles.
  - Any missing code reads 0 and sets `res_fine_err`.
- **Timeout**
  - The counter clears on entry to WAIT_START and counts through MEASURE.
  - When it reaches `TIMEOUT_CYC`: go to OUTPUT with `res_timeout`=1.
  - Latched values on timeout: `res_coarse` = current `coarse` (0 if no start was seen), fine codes 0, `res_fine_err`=0.
- **OUTPUT**
  - `res_valid`=1; the record is held stable until `res_ready`.
  - `res_last`=1 when `remaining`==1.
  - On handshake:
    - If `remaining`>1: decrement `remaining`, go to WAIT_START.
    - Otherwise go to IDLE.
- **Abort**
  - `abort` in any state forces IDLE on the next edge and drops `res_valid`; no record is produced.
  - `abort` takes priority over all other events in the same cycle.

## Timing
- **Reset values:** `arm_ready`=1 (IDLE); `fe_enable`, `res_valid`, `res_timeout`, `res_fine_err`, `res_last` and `busy` are 0; result data is 0.
- **Arm latency:** `arm_valid` accepted at edge N gives `fe_enable`=1 from N+1.
- **Start:** `tdc_start` at edge S puts the block in MEASURE with `coarse`=0 from S+1.
- **Stop:** `tdc_stop` sampled at edge S+k gives `res_coarse`=k-1.
- **Result latency:** `res_valid` rises one cycle after the WAIT_FINE exit condition.
- **Between measurements of a burst:** `fe_enable` is low for exactly the OUTPUT cycles. A `tdc_start` during OUTPUT is ignored.
- **Outputs are registered:**
  - `res_*` are registered; no combinational path from inputs to `res_*`.
  - `arm_ready` and `fe_enable` are decoded from the state register only.
- **Back-to-back host:** with `res_ready` held high, OUTPUT lasts exactly one cycle.

## Structure
- Package `tdc_pkg` holds:
  - the state enum,
  - the result record struct (coarse, fine_start, fine_stop, timeout, fine_err, last),
  - the default width constants.
- One sub-module, `tdc_fine_capture`: a two-channel first-valid latch with captured flags and a clear input. The FSM, coarse/timeout counters and output register live in the top.

## Test plan
- **Single measurement:** `arm_count`=1, `tdc_start` at cycle 10, `tdc_stop` at cycle 30, fine codes 0x12 and 0x34 one cycle after each pulse → one record: `res_coarse`=19, fines 0x12/0x34, `res_last`=1, `busy` falls after the handshake.
- **Timeout:** `TIMEOUT_CYC`=50, arm, never start → record with `res_timeout`=1, `res_coarse`=0, at cycle 51 after arm.
- **Missing fine code:** stop fine valid never asserted → after 4 WAIT_FINE cycles, `res_fine_stop`=0 and `res_fine_err`=1.
- **Burst with backpressure:** `arm_count`=3, `res_ready` held low for 5 cycles on each record → three records, data stable while stalled, `res_last` only on the third.
- **Abort:** abort mid-MEASURE → IDLE next cycle, `fe_enable`=0, no `res_valid`; an immediate re-arm works.
- **Coincident pulses:** `tdc_start` and `tdc_stop` in the same cycle in WAIT_START → treated as start; coarse saturation checked with `COARSE_W`=4 and a 20-cycle interval gives `res_coarse`=15.
